// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_receiver
//  Purpose  : PS/2 keyboard front end. Synchronises and de-glitches the raw
//             PS/2 clock/data lines, deserialises 11-bit device-to-host
//             frames, folds the E0 (extended) and F0 (break) prefixes into
//             complete key events and tracks the currently held key.
//
//  Parameters
//    FILTER_LEN      consecutive equal synced samples before the filtered
//                    PS/2 clock is allowed to change level
//    TIMEOUT_CYCLES  idle clk cycles tolerated between falling edges inside
//                    a frame before the frame is abandoned
//
//  Ports
//    clk        in   1   system clock
//    rst        in   1   asynchronous, active-high reset
//    ps2_clk    in   1   raw PS/2 clock from the connector
//    ps2_data   in   1   raw PS/2 data from the connector
//    xkey       out  16  held key {E0/00, scan code}; 0 when nothing is held
//    key_code   out  16  code of the most recent event, same format as xkey
//    key_valid  out  1   one-cycle strobe: key_code/key_break were updated
//    key_break  out  1   1 = most recent event was a release
//    frame_err  out  1   one-cycle strobe on parity, stop-bit or timeout error
//
//  Revision : 1.0  initial release
// ============================================================================
module ps2_scan_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] xkey,
    output logic [15:0] key_code,
    output logic        key_valid,
    output logic        key_break,
    output logic        frame_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int                  c_flt_w   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_flt_w-1:0]  c_flt_max = c_flt_w'(FILTER_LEN - 1);
    localparam int                  c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0]   c_to_max  = c_to_w'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0]          c_byte_ext = 8'hE0;
    localparam logic [7:0]          c_byte_brk = 8'hF0;

    // Frame deserialiser states
    localparam logic [0:0] F_IDLE  = 1'b0;
    localparam logic [0:0] F_SHIFT = 1'b1;

    // Prefix decoder states
    localparam logic [1:0] P_NONE    = 2'd0;
    localparam logic [1:0] P_EXT     = 2'd1;
    localparam logic [1:0] P_BRK     = 2'd2;
    localparam logic [1:0] P_EXT_BRK = 2'd3;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers. They reset to 1 so that a reset with the bus
    // idle does not look like a clock edge once it is released.
    // ------------------------------------------------------------------------
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_data_s1;
    logic r_data_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= ps2_data;
            r_data_s2 <= r_data_s1;
        end
    end

    // ------------------------------------------------------------------------
    // PS/2 clock glitch filter. The counter tracks how many consecutive synced
    // samples disagree with the filtered level; the filtered level flips on
    // the FILTER_LEN-th disagreeing sample. Any agreeing sample restarts the
    // count, so short spikes never reach the deserialiser.
    // ------------------------------------------------------------------------
    logic                r_clk_flt;
    logic [c_flt_w-1:0]  r_flt_cnt;
    logic                w_flt_flip;
    logic                w_fall;

    assign w_flt_flip = (r_clk_s2 != r_clk_flt) && (r_flt_cnt == c_flt_max);
    // Falling edge is flagged in the cycle the filtered level is about to drop,
    // so data is sampled from the same synchroniser stage in that cycle.
    assign w_fall     = w_flt_flip && r_clk_flt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_flt <= 1'b1;
            r_flt_cnt <= '0;
        end else if (r_clk_s2 == r_clk_flt) begin
            r_flt_cnt <= '0;
        end else if (w_flt_flip) begin
            r_clk_flt <= r_clk_s2;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame deserialiser.
    //   r_bit_cnt counts falls after the start bit: 0..7 data (LSB first),
    //   8 parity, 9 stop. A completed good byte is handed to the prefix
    //   decoder as a one-cycle r_byte_rdy strobe; a bad frame or an
    //   inter-edge timeout raises frame_err instead.
    // ------------------------------------------------------------------------
    logic [0:0]         r_fstate;
    logic [3:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par_ok;
    logic [c_to_w-1:0]  r_to_cnt;
    logic               r_byte_rdy;
    logic [7:0]         r_byte;
    logic               r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fstate    <= F_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_par_ok    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_rdy  <= 1'b0;
            r_byte      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_fstate)
                F_IDLE: begin
                    r_to_cnt <= '0;
                    // A fall with data high is not a start bit; ignore it.
                    if (w_fall && !r_data_s2) begin
                        r_fstate  <= F_SHIFT;
                        r_bit_cnt <= 4'd0;
                    end
                end

                F_SHIFT: begin
                    if (w_fall) begin
                        // An edge arriving on the limit cycle still counts.
                        r_to_cnt  <= '0;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt < 4'd8) begin
                            r_shift <= {r_data_s2, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            // Odd parity over data and parity bit.
                            r_par_ok <= ^{r_shift, r_data_s2};
                        end else begin
                            r_fstate <= F_IDLE;
                            if (r_par_ok && r_data_s2) begin
                                r_byte_rdy <= 1'b1;
                                r_byte     <= r_shift;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                    end else if (r_to_cnt == c_to_max) begin
                        r_fstate    <= F_IDLE;
                        r_to_cnt    <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end

                default: begin
                    r_fstate <= F_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Prefix decoder. E0 and F0 accumulate into the state; any other byte is
    // a code byte that closes the sequence with one event. Keyboard status
    // replies are only meaningful outside a sequence, so they are dropped
    // there and treated as ordinary codes anywhere else.
    // ------------------------------------------------------------------------
    logic [1:0]  r_pstate;
    logic [1:0]  w_pnext;
    logic        w_emit;
    logic        w_ext;
    logic        w_brk;
    logic        w_nonkey;
    logic [15:0] w_code;

    always_comb begin
        w_nonkey = 1'b0;
        case (r_byte)
            8'hAA, 8'hFA, 8'hEE, 8'hFE,
            8'hFC, 8'h00, 8'hFF, 8'hE1: w_nonkey = 1'b1;
            default:                    w_nonkey = 1'b0;
        endcase
    end

    always_comb begin
        w_pnext = r_pstate;
        w_emit  = 1'b0;
        w_ext   = (r_pstate == P_EXT) || (r_pstate == P_EXT_BRK);
        w_brk   = (r_pstate == P_BRK) || (r_pstate == P_EXT_BRK);

        if (r_byte_rdy) begin
            case (r_pstate)
                P_NONE: begin
                    if (r_byte == c_byte_ext) begin
                        w_pnext = P_EXT;
                    end else if (r_byte == c_byte_brk) begin
                        w_pnext = P_BRK;
                    end else if (!w_nonkey) begin
                        w_emit = 1'b1;
                    end
                end
                P_EXT: begin
                    if (r_byte == c_byte_ext) begin
                        w_pnext = P_EXT;
                    end else if (r_byte == c_byte_brk) begin
                        w_pnext = P_EXT_BRK;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                P_BRK: begin
                    // E0 after a bare F0 is taken as a code byte.
                    if (r_byte != c_byte_brk) begin
                        w_emit = 1'b1;
                    end
                end
                P_EXT_BRK: begin
                    if (r_byte == c_byte_ext) begin
                        w_pnext = P_EXT;
                    end else if (r_byte != c_byte_brk) begin
                        w_emit = 1'b1;
                    end
                end
                default: begin
                    w_pnext = P_NONE;
                end
            endcase

            if (w_emit) begin
                w_pnext = P_NONE;
            end
        end
    end

    assign w_code = {(w_ext ? 8'hE0 : 8'h00), r_byte};

    // ------------------------------------------------------------------------
    // Event registers and held-key tracking. A make always takes over xkey
    // (typematic repeats included); a break only releases xkey if it names
    // the key currently held.
    // ------------------------------------------------------------------------
    logic [15:0] r_xkey;
    logic [15:0] r_key_code;
    logic        r_key_valid;
    logic        r_key_break;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate    <= P_NONE;
            r_xkey      <= 16'h0000;
            r_key_code  <= 16'h0000;
            r_key_valid <= 1'b0;
            r_key_break <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;

            // A broken frame abandons any partially received sequence.
            if (r_frame_err) begin
                r_pstate <= P_NONE;
            end else begin
                r_pstate <= w_pnext;
            end

            if (w_emit && !r_frame_err) begin
                r_key_code  <= w_code;
                r_key_break <= w_brk;
                r_key_valid <= 1'b1;
                if (!w_brk) begin
                    r_xkey <= w_code;
                end else if (w_code == r_xkey) begin
                    r_xkey <= 16'h0000;
                end
            end
        end
    end

    assign xkey      = r_xkey;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_break = r_key_break;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire
